jk_mod_counter: RTL and testbench

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_stage.sv | 46 ++++
 rtl/jk_mod_counter.sv | 102 ++++++++++
 tb/tb_jk_mod_counter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK-based modulo counter.
//   JK_* : per-bit JK commands, encoded as {j, k}
//   DEFAULT_WIDTH / DEFAULT_MODULUS : default counter geometry
//   jk_cmd() : picks the JK command that moves one bit from its current to its next value
package jk_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DEFAULT_MODULUS = 10;

  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t JK_HOLD   = 2'b00;
  localparam jk_cmd_t JK_RESET  = 2'b01;
  localparam jk_cmd_t JK_SET    = 2'b10;
  localparam jk_cmd_t JK_TOGGLE = 2'b11;

  // Unchanged bits hold; changing bits are forced explicitly to their target value.
  function automatic jk_cmd_t jk_cmd(input logic cur, input logic nxt);
    if (cur == nxt) begin
      return JK_HOLD;
    end
    return nxt ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_stage.sv
// One JK flip-flop bit.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (q_o = 0, qbar_o = 1)
//   j_i    : J input
//   k_i    : K input
//   q_o    : stored bit
//   qbar_o : complement of q_o, registered alongside it so both change on the same edge
module jk_stage
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o,
  output logic qbar_o
);

  logic q_q;
  logic q_d;
  logic qbar_q;

  always_comb begin
    q_d = q_q;
    unique case ({j_i, k_i})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= 1'b0;
      qbar_q <= 1'b1;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
    end
  end

  assign q_o    = q_q;
  assign qbar_o = qbar_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from WIDTH JK stages.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : synchronous parallel load (takes priority over en)
//   load_val : value to load; values >= MODULUS load 0 and set err
//   clr_err  : clears err (an illegal load on the same edge wins)
//   q / qbar : registered count and its complement
//   tc       : combinational terminal count, true when this edge will wrap
//   wrap     : one-cycle pulse the cycle after a wrap
//   err      : sticky illegal-load flag
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable in the legality compare.
  localparam logic [WIDTH:0]   ModExt = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d;
  logic             load_ok;
  logic             wrap_d, wrap_q;
  logic             err_d, err_q;

  assign load_ok = ({1'b0, load_val} < ModExt);

  always_comb begin
    q_d = q;
    if (load) begin
      q_d = load_ok ? load_val : '0;
    end else if (en) begin
      if (up) begin
        q_d = (q == MaxVal) ? '0 : q + 1'b1;
      end else begin
        q_d = (q == '0) ? MaxVal : q - 1'b1;
      end
    end
  end

  assign tc = en & ~load & ((up & (q == MaxVal)) | (~up & (q == '0)));

  // tc already means "this edge wraps", so the pulse is just tc delayed by one cycle.
  assign wrap_d = tc;

  always_comb begin
    err_d = err_q;
    if (load && !load_ok) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
    jk_cmd_t cmd;
    assign cmd = jk_cmd(q[i], q_d[i]);

    jk_stage u_stage (
      .clk    (clk),
      .rst    (rst),
      .j_i    (cmd[1]),
      .k_i    (cmd[0]),
      .q_o    (q[i]),
      .qbar_o (qbar[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Randomized self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10) against an
// arithmetic reference model.
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         clr_err = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;
  logic         wrap;
  logic         err;

  int total = 0;
  int bad = 0;

  // Reference model state
  int mq = 0;
  bit merr = 1'b0;
  bit mwrap = 1'b0;
  int mwraps = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(
    .WIDTH   (W),
    .MODULUS (M)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .clr_err  (clr_err),
    .q        (q),
    .qbar     (qbar),
    .tc       (tc),
    .wrap     (wrap),
    .err      (err)
  );

  function automatic logic exp_tc();
    return en && !load && ((up && mq == M - 1) || (!up && mq == 0));
  endfunction

  function automatic logic [W-1:0] exp_q();
    return W'(mq);
  endfunction

  task automatic model_reset();
    mq    = 0;
    merr  = 1'b0;
    mwrap = 1'b0;
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input int lv, input logic c);
    @(negedge clk);
    en       = e;
    up       = u;
    load     = l;
    load_val = W'(lv);
    clr_err  = c;
    #1;
  endtask

  // Advance one rising edge and update the model from the currently driven inputs.
  task automatic tick();
    int nq;
    bit nw;
    bit ne;
    nq = mq;
    nw = 1'b0;
    ne = merr;
    if (load) begin
      nq = (int'(load_val) < M) ? int'(load_val) : 0;
    end else if (en) begin
      if (up) begin
        nq = (mq + 1) % M;
        nw = (mq == M - 1);
      end else begin
        nq = (mq + M - 1) % M;
        nw = (mq == 0);
      end
    end
    if (load && int'(load_val) >= M) ne = 1'b1;
    else if (clr_err) ne = 1'b0;
    @(posedge clk);
    mq    = nq;
    mwrap = nw;
    merr  = ne;
    if (nw) mwraps++;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++; if (q !== 4'h0) begin bad++; $display("FAIL reset_q: got %0h want 0", q); end
    total++; if (qbar !== 4'hF) begin bad++; $display("FAIL reset_qbar: got %0h want f", qbar); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (q !== 4'h0) begin bad++; $display("FAIL reset_hold_q: got %0h want 0", q); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    int seen;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
      total++; if (tc !== exp_tc()) begin bad++; $display("FAIL up_tc: got %0b want %0b", tc, exp_tc()); end
      tick();
      total++; if (q !== W'((k + 1) % M)) begin bad++; $display("FAIL up_q: got %0d want %0d", q, (k + 1) % M); end
      total++; if (qbar !== ~exp_q()) begin bad++; $display("FAIL up_qbar: got %0h want %0h", qbar, ~exp_q()); end
      total++; if (wrap !== mwrap) begin bad++; $display("FAIL up_wrap: got %0b want %0b", wrap, mwrap); end
      if (wrap) seen++;
    end
    total++; if (seen != 1) begin bad++; $display("FAIL up_wrap_count: got %0d want 1", seen); end
  endtask

  task automatic test_load_down();
    int seen;
    seen = 0;
    drive(1'b0, 1'b0, 1'b1, 3, 1'b0);
    tick();
    total++; if (q !== 4'd3) begin bad++; $display("FAIL load3_q: got %0d want 3", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL load3_wrap: got %0b want 0", wrap); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
      total++; if (tc !== exp_tc()) begin bad++; $display("FAIL down_tc: got %0b want %0b", tc, exp_tc()); end
      tick();
      total++; if (q !== exp_q()) begin bad++; $display("FAIL down_q: got %0d want %0d", q, mq); end
      total++; if (wrap !== mwrap) begin bad++; $display("FAIL down_wrap: got %0b want %0b", wrap, mwrap); end
      if (wrap) seen++;
    end
    total++; if (q !== 4'd8) begin bad++; $display("FAIL down_final_q: got %0d want 8", q); end
    total++; if (seen != 1) begin bad++; $display("FAIL down_wrap_count: got %0d want 1", seen); end
  endtask

  task automatic test_illegal_load();
    drive(1'b1, 1'b1, 1'b1, 12, 1'b0);
    tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL illegal_q: got %0d want 0", q); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %0b want 1", err); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_err: got %0b want 0", err); end
    drive(1'b0, 1'b0, 1'b1, 12, 1'b1);
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_and_clr_err: got %0b want 1", err); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL illegal_and_clr_q: got %0d want 0", q); end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    tick();
    total++; if (err !== merr) begin bad++; $display("FAIL clr_err_again: got %0b want %0b", err, merr); end
  endtask

  task automatic test_load_priority();
    drive(1'b0, 1'b0, 1'b1, 9, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5, 1'b0);
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL prio_tc: got %0b want 0", tc); end
    tick();
    total++; if (q !== 4'd5) begin bad++; $display("FAIL prio_q: got %0d want 5", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL prio_wrap: got %0b want 0", wrap); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b1, 7, 1'b0);
    tick();
    total++; if (q !== 4'd7) begin bad++; $display("FAIL ar_pre_q: got %0d want 7", q); end
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL ar_q: got %0d want 0", q); end
    total++; if (qbar !== 4'hF) begin bad++; $display("FAIL ar_qbar: got %0h want f", qbar); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ar_wrap: got %0b want 0", wrap); end
    @(posedge clk);
    #1;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL ar_hold_q: got %0d want 0", q); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (q !== 4'd1) begin bad++; $display("FAIL ar_first_count: got %0d want 1", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ar_release_wrap: got %0b want 0", wrap); end
    // Reset while a wrap pulse is showing must kill it at once and not let it reappear.
    drive(1'b0, 1'b0, 1'b1, 9, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
    tick();
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL ar_pending_wrap: got %0b want 1", wrap); end
    rst = 1'b1;
    #1;
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ar_abort_wrap: got %0b want 0", wrap); end
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    tick();
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ar_after_wrap: got %0b want 0", wrap); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL ar_after_q: got %0d want 0", q); end
  endtask

  task automatic test_random();
    int dwraps;
    int w0;
    logic e, u, l, c;
    int lv;
    dwraps = 0;
    w0 = mwraps;
    for (int k = 0; k < 10000; k++) begin
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 1) != 0);
      l  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 3) == 0);
      lv = int'($urandom_range(0, 15));
      drive(e, u, l, lv, c);
      total++; if (tc !== exp_tc()) begin bad++; $display("FAIL rnd_tc: got %0b want %0b at %0d", tc, exp_tc(), k); end
      tick();
      total++; if (q !== exp_q()) begin bad++; $display("FAIL rnd_q: got %0d want %0d at %0d", q, mq, k); end
      total++; if (qbar !== ~q) begin bad++; $display("FAIL rnd_qbar: got %0h want %0h at %0d", qbar, ~q, k); end
      total++; if (int'(q) >= M) begin bad++; $display("FAIL rnd_range: got %0d want <%0d at %0d", q, M, k); end
      total++; if (wrap !== mwrap) begin bad++; $display("FAIL rnd_wrap: got %0b want %0b at %0d", wrap, mwrap, k); end
      total++; if (err !== merr) begin bad++; $display("FAIL rnd_err: got %0b want %0b at %0d", err, merr, k); end
      if (wrap) dwraps++;
    end
    total++; if (dwraps != mwraps - w0) begin bad++; $display("FAIL rnd_wrap_count: got %0d want %0d", dwraps, mwraps - w0); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_illegal_load();
    test_load_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
